// File: rtl/gf_divider_scheduler.sv
// Shared GF(2^M) division service.
//
// gf_fermat_divider computes numer/denom by Fermat inversion
// (denom^(2^M - 2), built by repeated squaring) followed by one multiply.
// It returns the quotient in the trace-dual basis: bit i = Tr(q * alpha^i).
//
// gf_divider_scheduler arbitrates round-robin among N_REQ requesters,
// sequences the divider and holds one result behind a valid/ready port.
//
// The field polynomial is the trinomial x^M + x^K + 1. With the defaults,
// M = 6 and K = 1, that is x^6 + x + 1. M must be at least 3.

module gf_fermat_divider #(
    parameter int M = 6,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         start,
    input  logic [M-1:0] standard_numer,
    input  logic [M-1:0] standard_denom,
    output logic         busy,
    output logic [M-1:0] dual_out
);
    localparam int           CNT_W    = $clog2(M);
    localparam logic [M-1:0] POLY_LOW = M'((1 << K) | 1);

    logic [M-1:0]     sq_q;
    logic [M-1:0]     inv_q;
    logic [CNT_W-1:0] cnt_q;
    logic [M-1:0]     sq_next;

    // Multiply by alpha, reducing by the trinomial.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LOW : '0);
    endfunction

    // Shift-and-add field multiply.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc ^= sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Absolute trace. The result is always the element 0 or the element 1,
    // so OR-reducing it gives the single trace bit.
    function automatic logic gf_trace(input logic [M-1:0] a);
        logic [M-1:0] s;
        logic [M-1:0] t;
        s = a;
        t = a;
        for (int i = 1; i < M; i++) begin
            s = gf_mul(s, s);
            t ^= s;
        end
        return |t;
    endfunction

    // Standard basis to trace-dual basis: bit i = Tr(q * alpha^i).
    function automatic logic [M-1:0] to_dual(input logic [M-1:0] q);
        logic [M-1:0] p;
        logic [M-1:0] d;
        p = q;
        d = '0;
        for (int i = 0; i < M; i++) begin
            d[i] = gf_trace(p);
            p    = xtime(p);
        end
        return d;
    endfunction

    assign sq_next = gf_mul(sq_q, sq_q);

    // Square-and-accumulate. start loads d^2, and each busy cycle then
    // multiplies in the next d^(2^k). After M-2 busy cycles,
    // inv_q = d^(2^M - 2) = 1/d.
    // NOTE: sequential state uses non-blocking assignments, so every register in this block samples pre-edge values.
    // NOTE: these registers deliberately have no reset; the scheduler's FLUSH state waits for busy to drain instead.
    always_ff @(posedge clk) begin
        if (start) begin
            sq_q  <= gf_mul(standard_denom, standard_denom);
            inv_q <= gf_mul(standard_denom, standard_denom);
            cnt_q <= CNT_W'(M - 2);
        end else if (cnt_q != '0) begin
            sq_q  <= sq_next;
            inv_q <= gf_mul(inv_q, sq_next);
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy     = (cnt_q != '0);
    assign dual_out = to_dual(gf_mul(standard_numer, inv_q));

endmodule

module gf_divider_scheduler #(
    parameter int M     = 6,
    parameter int N_REQ = 3,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [M*N_REQ-1:0] req_numer,
    input  logic [M*N_REQ-1:0] req_denom,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [M-1:0]       out_data,
    output logic [ID_W-1:0]    out_id,
    output logic               out_div0,
    output logic               active
);
    typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, CAPTURE, RESULT} state_t;

    state_t          state_q;
    state_t          state_d;
    logic            skip_q;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_next;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            accept;
    logic [M-1:0]    sel_numer;
    logic [M-1:0]    sel_denom;
    logic [M-1:0]    numer_q;
    logic [M-1:0]    denom_q;
    logic [ID_W-1:0] id_q;
    logic            div0_q;
    logic            div_start;
    logic            div_busy;
    logic [M-1:0]    div_dual;

    // Round-robin search: the first valid requester at or after rr_ptr.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign accept  = (state_q == IDLE) && !reset && grant_found;
    assign rr_next = (int'(grant_id) + 1 >= N_REQ) ? '0 : grant_id + 1'b1;
    assign active  = (state_q != IDLE);

    // Ready is a one-hot grant, offered only in IDLE.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_numer = '0;
        sel_denom = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_numer = req_numer[i*M +: M];
                sel_denom = req_denom[i*M +: M];
            end
        end
    end

    // State register. skip_q marks the first WAIT cycle, while busy is still rising.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FLUSH;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= (state_q == ISSUE);
        end
    end

    // Next-state logic and divider start strobe.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            FLUSH:   if (!div_busy) state_d = IDLE;
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT:    if (!skip_q && !div_busy) state_d = CAPTURE;
            CAPTURE: state_d = RESULT;
            RESULT:  if (out_ready) state_d = IDLE;
            default: state_d = FLUSH;
        endcase
    end

    // Control-visible registers: round-robin pointer and the result port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_div0  <= 1'b0;
        end else begin
            if (accept) rr_ptr <= rr_next;
            if (state_q == CAPTURE) begin
                out_valid <= 1'b1;
                out_data  <= div0_q ? '0 : div_dual;
                out_id    <= id_q;
                out_div0  <= div0_q;
            end else if (state_q == RESULT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Operand capture on accept. These registers are only read after a fresh accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            numer_q <= sel_numer;
            denom_q <= sel_denom;
            id_q    <= grant_id;
            div0_q  <= (sel_denom == '0);
        end
    end

    gf_fermat_divider #(
        .M (M),
        .K (1)
    ) u_divider (
        .clk            (clk),
        .start          (div_start),
        .standard_numer (numer_q),
        .standard_denom (denom_q),
        .busy           (div_busy),
        .dual_out       (div_dual)
    );

endmodule

// File: tb/tb_gf_divider_scheduler.sv
// Scoreboard bench for gf_divider_scheduler (M=6, N_REQ=3, field x^6+x+1).
// Expected quotients come from log/antilog tables and a trace sum;
// the round-robin order and the timing come from the block's behaviour.
module tb_gf_divider_scheduler;
    localparam int M     = 6;
    localparam int N_REQ = 3;
    localparam int ID_W  = 2;
    localparam int LAT   = M + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [M*N_REQ-1:0] req_numer;
    logic [M*N_REQ-1:0] req_denom;
    logic               out_valid;
    logic               out_ready;
    logic [M-1:0]       out_data;
    logic [ID_W-1:0]    out_id;
    logic               out_div0;
    logic               active;

    logic [M-1:0] numer_a [N_REQ];
    logic [M-1:0] denom_a [N_REQ];

    gf_divider_scheduler #(.M(M), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_numer (req_numer),
        .req_denom (req_denom),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_div0  (out_div0),
        .active    (active)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_numer[i*M +: M] = numer_a[i];
            req_denom[i*M +: M] = denom_a[i];
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference field: antilog/log tables for x^6 + x + 1.
    int alog [63];
    int glog [64];

    function automatic void build_tables();
        int v;
        v = 1;
        for (int e = 0; e < 63; e++) begin
            alog[e] = v;
            glog[v] = e;
            v = v << 1;
            if ((v & 64) != 0) v = v ^ 'h43;
        end
    endfunction

    function automatic int gf_div(int n, int d);
        if (n == 0 || d == 0) return 0;
        return alog[(glog[n] - glog[d] + 63) % 63];
    endfunction

    // Tr(z) = sum of z^(2^k) for k = 0..M-1, computed in the log domain.
    function automatic int trace(int z);
        int t;
        int e;
        if (z == 0) return 0;
        t = 0;
        e = glog[z];
        for (int k = 0; k < M; k++) begin
            t = t ^ alog[e];
            e = (e * 2) % 63;
        end
        return t;
    endfunction

    function automatic logic [M-1:0] model_quot(int n, int d);
        logic [M-1:0] r;
        int q;
        r = '0;
        q = gf_div(n, d);
        if (q != 0)
            for (int i = 0; i < M; i++) r[i] = (trace(alog[(glog[q] + i) % 63]) != 0);
        return r;
    endfunction

    function automatic int model_grant(logic [N_REQ-1:0] v, int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    typedef struct {
        logic [ID_W-1:0] id;
        logic [M-1:0]    data;
        logic            div0;
        int              due;
    } sb_entry_t;

    sb_entry_t        sb[$];
    int               grant_log[$];
    logic [N_REQ-1:0] acc_vec = '0;
    logic             model_busy = 1'b0;
    logic             flushing = 1'b1;
    logic             presenting = 1'b0;
    int               rr_m = 0;
    int               flush_cnt = 0;
    int               results = 0;
    int               last_accept = 0;
    logic             have_last = 1'b0;
    logic             spacing_on = 1'b0;
    logic [M-1:0]     held_data;
    logic [ID_W-1:0]  held_id;
    logic             held_div0;
    int               g;
    logic [N_REQ-1:0] exp_vec;
    sb_entry_t        e;

    // Monitor: samples mid-cycle and predicts grants and results independently of the stimulus thread.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            model_busy = 1'b0;
            flushing   = 1'b1;
            flush_cnt  = 0;
            presenting = 1'b0;
            rr_m       = 0;
            check("reset_out_valid", out_valid, 0);
            check("reset_req_ready", req_ready, 0);
        end else begin
            g = model_grant(req_valid, rr_m);
            exp_vec = (g < 0) ? '0 : N_REQ'(1 << g);
            if (|req_ready) begin
                check("grant_vector", req_ready, exp_vec);
                check("grant_while_busy", model_busy, 0);
                if (g >= 0) begin
                    e.id   = ID_W'(g);
                    e.data = model_quot(int'(numer_a[g]), int'(denom_a[g]));
                    e.div0 = (denom_a[g] == '0);
                    e.due  = cycle + LAT;
                    sb.push_back(e);
                    grant_log.push_back(g);
                    if (spacing_on && have_last) check("accept_spacing", cycle - last_accept, M + 3);
                    last_accept = cycle;
                    have_last   = 1'b1;
                    acc_vec[g]  = 1'b1;
                    rr_m        = (g + 1) % N_REQ;
                    model_busy  = 1'b1;
                    flushing    = 1'b0;
                end
            end else if (|req_valid) begin
                if (!model_busy && !flushing) begin
                    check("grant_missing", req_ready, exp_vec);
                end else if (flushing) begin
                    flush_cnt++;
                    if (flush_cnt > 2 * M + 4) begin
                        checks++;
                        errors++;
                        $display("FAIL flush_timeout: no grant %0d cycles after reset (cycle %0d)", flush_cnt, cycle);
                        flushing = 1'b0;
                    end
                end
            end

            if (out_valid) begin
                check("ready_during_result", req_ready, 0);
                if (!presenting) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: id %0d data 0x%0h with nothing outstanding (cycle %0d)", out_id, out_data, cycle);
                    end else begin
                        e = sb.pop_front();
                        check("result_id", out_id, e.id);
                        check("result_data", out_data, e.data);
                        check("result_div0", out_div0, e.div0);
                        check("result_latency", cycle, e.due);
                        results++;
                    end
                    presenting = 1'b1;
                    held_data  = out_data;
                    held_id    = out_id;
                    held_div0  = out_div0;
                end else begin
                    check("hold_data", out_data, held_data);
                    check("hold_id", out_id, held_id);
                    check("hold_div0", out_div0, held_div0);
                end
                if (out_ready) begin
                    presenting = 1'b0;
                    model_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int n, input int d);
        numer_a[i]   = M'(n);
        denom_a[i]   = M'(d);
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_ops(input int i);
        numer_a[i] = M'($urandom_range(0, 63));
        denom_a[i] = ($urandom_range(0, 15) == 0) ? '0 : M'($urandom_range(0, 63));
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cycle);
    endtask

    task automatic wait_accept(input int i);
        int n;
        n = 0;
        while (!acc_vec[i] && n < 60) begin
            tick();
            n++;
        end
        if (!acc_vec[i]) fail_timeout("wait_accept");
        acc_vec[i]   = 1'b0;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || presenting) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_timeout("drain");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset   = 1'b0;
        acc_vec = '0;
    endtask

    int old_accept;
    int target;
    int n;

    initial begin
        build_tables();
        reset     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            numer_a[i] = '0;
            denom_a[i] = '0;
        end
        repeat (3) tick();
        check("reset_out_data", out_data, 0);
        check("reset_out_id", out_id, 0);
        check("reset_out_div0", out_div0, 0);
        check("reset_active", active, 1);
        reset = 1'b0;

        // Single request: 1/1 from requester 1.
        set_req(1, 1, 1);
        wait_accept(1);
        drain();

        // Round-robin with every requester permanently valid.
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            rand_ops(i);
            req_valid[i] = 1'b1;
        end
        repeat (2) tick();
        reset      = 1'b0;
        acc_vec    = '0;
        grant_log.delete();
        have_last  = 1'b0;
        spacing_on = 1'b1;
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin
            tick();
            n++;
            for (int i = 0; i < N_REQ; i++)
                if (acc_vec[i]) begin
                    acc_vec[i] = 1'b0;
                    rand_ops(i);
                end
        end
        req_valid  = '0;
        spacing_on = 1'b0;
        if (grant_log.size() < 6) fail_timeout("rr_grants");
        for (int k = 0; k < 6 && k < grant_log.size(); k++) check("rr_order", grant_log[k], k % N_REQ);
        acc_vec = '0;
        drain();

        // Backpressure, with requester 2 pending while the result is held.
        out_ready = 1'b0;
        set_req(0, 'h13, 'h07);
        wait_accept(0);
        set_req(2, 'h3F, 'h21);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) fail_timeout("bp_out_valid");
        repeat (20) tick();
        out_ready = 1'b1;
        wait_accept(2);
        drain();

        // Zero denominator, then zero numerator.
        set_req(2, 'h2A, 0);
        wait_accept(2);
        drain();
        set_req(0, 0, 'h15);
        wait_accept(0);
        drain();

        // Reset in cycle 4 of a division. The stale result must never
        // appear, and the next request must not be granted before the
        // divider has drained.
        set_req(1, 'h05, 'h0B);
        wait_accept(1);
        old_accept = last_accept;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        acc_vec = '0;
        check("flush_active", active, 1);
        set_req(0, 'h31, 'h1C);
        wait_accept(0);
        check("flush_hold", (last_accept - old_accept) >= M + 1, 1);
        drain();

        // Random regression: 1000 divisions.
        target = results + 1000;
        n = 0;
        while (results < target && n < 40000) begin
            tick();
            n++;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_vec[i]) begin
                    acc_vec[i]   = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rand_ops(i);
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    rand_ops(i);
                end
            end
        end
        if (results < target) fail_timeout("random_results");
        req_valid = '0;
        tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "global timeout");
    end

endmodule
